// File: rtl/pkt_wsched_pkg.sv
// rtl/pkt_wsched_pkg.sv - shared types and defaults for the weighted packet scheduler
package pkt_wsched_pkg;

    localparam int WEIGHT_W_C   = 4;
    localparam int DEF_WEIGHT_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_BUSY   = 2'd2
    } wsched_state_e;

endpackage

// File: rtl/wsched_rr_pick.sv
// rtl/wsched_rr_pick.sv - combinational rotating-priority picker
//   eligible : per-requester candidate mask
//   ptr      : index that has highest priority this round
//   onehot   : one-hot winner (zero when nothing eligible)
//   idx      : encoded winner
//   found    : high when any candidate is eligible
module wsched_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int pos;

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && eligible[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/pkt_weighted_scheduler.sv
// rtl/pkt_weighted_scheduler.sv - credit-weighted round-robin packet grant scheduler
//   clk, rst             : clock, synchronous active-high reset
//   req                  : per-requester packet request (level)
//   xfer, xfer_last      : owner beat strobe and end-of-packet marker
//   cfg_we/idx/weight    : weight write port
//   gnt, gnt_id, busy    : registered one-hot grant, encoded owner, grant held
module pkt_weighted_scheduler
    import pkt_wsched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WEIGHT_W   = WEIGHT_W_C,
    parameter int DEF_WEIGHT = DEF_WEIGHT_C,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                xfer,
    input  logic                xfer_last,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [IDX_W-1:0]    gnt_id,
    output logic                busy
);

    wsched_state_e       state_q, state_d;
    logic [WEIGHT_W-1:0] weight [NUM_REQ];
    logic [WEIGHT_W-1:0] credit [NUM_REQ];
    logic [IDX_W-1:0]    ptr;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;

    logic                grant_load;
    logic                do_refill;
    logic                do_release;

    always_comb begin
        eligible = '0;
        pending  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] && (credit[i] != '0);
            pending[i]  = req[i] && (weight[i] != '0);
        end
    end

    wsched_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        do_refill  = 1'b0;
        do_release = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_load = 1'b1;
                    state_d    = ST_BUSY;
                end else if (|pending) begin
                    // Requests exist but every one is out of credit.
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                do_refill = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_BUSY: begin
                if (xfer && xfer_last) begin
                    do_release = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                weight[i] <= WEIGHT_W'(DEF_WEIGHT);
                credit[i] <= WEIGHT_W'(DEF_WEIGHT);
            end
        end else begin
            state_q <= state_d;
            if (grant_load) begin
                gnt    <= pick_onehot;
                gnt_id <= pick_idx;
                busy   <= 1'b1;
            end
            if (do_release) begin
                gnt  <= '0;
                busy <= 1'b0;
                if (credit[gnt_id] != '0) begin
                    credit[gnt_id] <= credit[gnt_id] - 1'b1;
                end
                ptr <= (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            // Refill reads weight before this cycle's cfg write lands.
            if (do_refill) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    credit[i] <= weight[i];
                end
            end
            if (cfg_we && (int'(cfg_idx) < NUM_REQ)) begin
                weight[cfg_idx] <= cfg_weight;
            end
        end
    end

endmodule

// File: tb/tb_pkt_weighted_scheduler.sv
// tb/tb_pkt_weighted_scheduler.sv - self-checking bench for pkt_weighted_scheduler
module tb_pkt_weighted_scheduler;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          xfer;
    logic          xfer_last;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [WW-1:0] cfg_weight;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pkt_weighted_scheduler #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .xfer       (xfer),
        .xfer_last  (xfer_last),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the link, what credits/weights are, and
    // whether a credit top-up is owed before anyone can be served again.
    bit m_owning;
    bit m_refill_due;
    int m_owner;
    int m_ptr;
    int m_w [N];
    int m_c [N];

    always @(posedge clk) begin
        int  win;
        bit  any;
        if (rst) begin
            m_owning     = 1'b0;
            m_refill_due = 1'b0;
            m_owner      = 0;
            m_ptr        = 0;
            for (int i = 0; i < N; i++) begin
                m_w[i] = DW;
                m_c[i] = DW;
            end
        end else begin
            if (m_owning) begin
                if (xfer && xfer_last) begin
                    if (m_c[m_owner] > 0) m_c[m_owner] = m_c[m_owner] - 1;
                    m_ptr    = (m_owner + 1) % N;
                    m_owning = 1'b0;
                end
            end else if (m_refill_due) begin
                for (int i = 0; i < N; i++) m_c[i] = m_w[i];
                m_refill_due = 1'b0;
            end else begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req[(m_ptr + k) % N] && m_c[(m_ptr + k) % N] > 0)
                        win = (m_ptr + k) % N;
                end
                if (win >= 0) begin
                    m_owning = 1'b1;
                    m_owner  = win;
                end else begin
                    any = 1'b0;
                    for (int i = 0; i < N; i++) if (req[i] && m_w[i] > 0) any = 1'b1;
                    m_refill_due = any;
                end
            end
            if (cfg_we && int'(cfg_idx) < N) m_w[cfg_idx] = int'(cfg_weight);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", int'(gnt), m_owning ? (1 << m_owner) : 0);
            check("busy", int'(busy), int'(m_owning));
            if (m_owning) check("gnt_id", int'(gnt_id), m_owner);
            for (int i = 0; i < N; i++) check("credit", int'(dut.credit[i]), m_c[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int waited, output int id);
        waited = 0;
        while (!busy && waited < 20) begin
            tick();
            waited++;
        end
        if (!busy) check("grant_timeout", 0, 1);
        id = int'(gnt_id);
    endtask

    task automatic one_beat_pkt();
        xfer      = 1'b1;
        xfer_last = 1'b1;
        tick();
        xfer      = 1'b0;
        xfer_last = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int ids   [10];
    int waits [10];
    int exp_a [7]  = '{0, 2, 0, 2, 0, 2, 0};
    int exp_b [10] = '{2, 0, 2, 0, 2, 0, 2, 2, 2, 0};
    int w, id, highs;

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; xfer = 1'b0; xfer_last = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gnt_id", int'(gnt_id), 0);
        check("rst_ptr", int'(dut.ptr), 0);

        // Equal weights, two requesters alternate until credits run dry.
        req = 4'b0101;
        for (int p = 0; p < 7; p++) begin
            wait_grant(waits[p], ids[p]);
            one_beat_pkt();
        end
        for (int p = 0; p < 7; p++) check("A_order", ids[p], exp_a[p]);
        for (int p = 1; p < 6; p++) check("A_gap", waits[p], 1);
        check("A_refill_gap", waits[6], 3);

        // Reweight requester 0 down to 1; after the next top-up, 2 gets 3 turns.
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_weight = 4'd1;
        tick();
        cfg_idx = 2'd2; cfg_weight = 4'd3;
        tick();
        cfg_we = 1'b0;
        for (int p = 0; p < 10; p++) begin
            wait_grant(waits[p], ids[p]);
            one_beat_pkt();
        end
        for (int p = 0; p < 10; p++) check("B_order", ids[p], exp_b[p]);
        check("B_refill_gap", waits[5], 3);
        for (int p = 6; p < 9; p++) check("B_gap", waits[p], 1);
        check("B_refill_gap2", waits[9], 3);

        // Long packet; owner drops req mid-packet, grant must hold.
        req = '0;
        pulse_reset();
        req = 4'b0010;
        wait_grant(w, id);
        check("C_owner", id, 1);
        for (int b = 1; b <= 5; b++) begin
            xfer      = 1'b1;
            xfer_last = (b == 5);
            if (b == 2) req = '0;
            tick();
            if (b < 5) check("C_hold_gnt", int'(gnt), 4'b0010);
        end
        xfer = 1'b0; xfer_last = 1'b0;
        check("C_released", int'(busy), 0);
        check("C_credit1", int'(dut.credit[1]), 2);
        xfer = 1'b1; xfer_last = 1'b1;
        tick();
        tick();
        xfer = 1'b0; xfer_last = 1'b0;
        check("C_stray_xfer", int'(dut.credit[1]), 2);

        // Weight 0 for requester 3: after the top-up it is never served.
        pulse_reset();
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_weight = 4'd0;
        tick();
        cfg_we = 1'b0;
        req = 4'b0001;
        for (int p = 0; p < 3; p++) begin
            wait_grant(w, id);
            one_beat_pkt();
        end
        tick();
        tick();
        req = 4'b1000;
        check("D_credit3", int'(dut.credit[3]), 0);
        check("D_credit0", int'(dut.credit[0]), 3);
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy || gnt != '0) highs++;
        end
        check("D_never_granted", highs, 0);

        // Reset mid-packet aborts without charging the owner.
        req = '0;
        pulse_reset();
        req = 4'b0100;
        wait_grant(w, id);
        check("E_owner", id, 2);
        xfer = 1'b1; xfer_last = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; xfer = 1'b0; req = '0;
        check("E_gnt", int'(gnt), 0);
        check("E_busy", int'(busy), 0);
        check("E_ptr", int'(dut.ptr), 0);
        for (int i = 0; i < N; i++) check("E_credit", int'(dut.credit[i]), 3);
        req = 4'b0100;
        wait_grant(w, id);
        check("E_regrant", id, 2);
        check("E_regrant_lat", w, 1);
        one_beat_pkt();
        req = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
